// File: rtl/fp_norm_sequencer.sv
// Multi-cycle significand normalizer: byte-serial leading-one search (MSB byte first)
// followed by a single shift/exponent-adjust cycle, with valid/ready on both sides.
module fp_norm_sequencer #(
    parameter int MANT_POS = 23,
    parameter int EXP_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_sig,
    input  logic [EXP_W-1:0] in_exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_sig,
    output logic [EXP_W-1:0] out_exp,
    output logic             out_zero,
    output logic             out_unf,
    output logic             out_ovf,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, SCAN, CALC, DONE} state_t;

    localparam int             XW      = EXP_W + 1;
    localparam logic [5:0]     MANT_P  = 6'(MANT_POS);
    localparam logic [XW-1:0]  EXP_MAX = XW'((1 << EXP_W) - 1);

    state_t           state;
    logic [31:0]      sig_r;
    logic [EXP_W-1:0] exp_r;
    logic [4:0]       pos_r;
    logic [1:0]       idx_r;

    // Shared 8-bit priority encoder applied to the currently selected byte
    logic [7:0] cur_byte;
    logic [2:0] hi_bit;
    logic       byte_nz;

    always_comb begin
        cur_byte = sig_r[{idx_r, 3'b000} +: 8];
        byte_nz  = |cur_byte;
        hi_bit   = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (cur_byte[i]) hi_bit = 3'(i);
        end
    end

    logic [5:0]    pos_x;
    logic [5:0]    d;
    logic          shift_left;
    logic [XW-1:0] exp_x;
    logic [XW-1:0] d_x;
    logic [XW-1:0] exp_dn;
    logic [XW-1:0] exp_up;

    always_comb begin
        pos_x      = {1'b0, pos_r};
        shift_left = (pos_x <= MANT_P);
        d          = shift_left ? (MANT_P - pos_x) : (pos_x - MANT_P);
        exp_x      = {1'b0, exp_r};
        d_x        = XW'(d);
        exp_dn     = exp_x - d_x;
        exp_up     = exp_x + d_x;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_sig   <= '0;
            out_exp   <= '0;
            out_zero  <= 1'b0;
            out_unf   <= 1'b0;
            out_ovf   <= 1'b0;
            sig_r     <= '0;
            exp_r     <= '0;
            pos_r     <= '0;
            idx_r     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sig_r    <= in_sig;
                        exp_r    <= in_exp;
                        idx_r    <= 2'd3;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    if (byte_nz) begin
                        pos_r <= {idx_r, hi_bit};
                        state <= CALC;
                    end else if (idx_r == 2'd0) begin
                        out_sig   <= '0;
                        out_exp   <= '0;
                        out_zero  <= 1'b1;
                        out_unf   <= 1'b0;
                        out_ovf   <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx_r <= idx_r - 2'd1;
                    end
                end
                CALC: begin
                    out_valid <= 1'b1;
                    out_zero  <= 1'b0;
                    state     <= DONE;
                    if (shift_left) begin
                        out_sig <= sig_r << d;
                        if (exp_x < d_x) begin
                            out_exp <= '0;
                            out_unf <= 1'b1;
                        end else begin
                            out_exp <= EXP_W'(exp_dn);
                        end
                    end else begin
                        out_sig <= sig_r >> d;
                        if (exp_up > EXP_MAX) begin
                            out_exp <= '1;
                            out_ovf <= 1'b1;
                        end else begin
                            out_exp <= EXP_W'(exp_up);
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_zero  <= 1'b0;
                        out_unf   <= 1'b0;
                        out_ovf   <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fp_norm_sequencer.md
Name: fp_norm_sequencer

Overview:
- Multi-cycle normalizer for the FP add/sub datapath: locates the leading one of a 32-bit raw significand and aligns it to bit MANT_POS.
- Adjusts the 8-bit exponent to match the alignment.
- Uses one shared 8-bit priority-encoder slice, iterated MSB byte first, instead of a full 32-bit combinational encoder.
- Valid/ready handshake on input and output; sits between the significand adder and the rounding stage.

Parameters:
- MANT_POS, 23, target bit position of the leading one (0..31).
- EXP_W, 8, exponent width; saturation limits are 0 and 2^EXP_W-1.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand valid.
- in_ready  output  1  block can accept an operand; high only in IDLE.
- in_sig  input  32  raw significand.
- in_exp  input  EXP_W  exponent before normalization.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  downstream accepts the result.
- out_sig  output  32  normalized significand.
- out_exp  output  EXP_W  adjusted exponent.
- out_zero  output  1  in_sig was zero.
- out_unf  output  1  exponent underflow; out_exp saturated to 0.
- out_ovf  output  1  exponent overflow; out_exp saturated to all-ones.
- busy  output  1  state is not IDLE.

Behaviour:
- Reset (async, any state): state = IDLE, in_ready = 1, busy = 0. out_valid, out_sig, out_exp and all flags = 0. Internal sig/exp/pos/byte-index registers are cleared. An operation in flight is discarded and no output is produced.
- States and transitions:
  - IDLE: in_ready = 1. On in_valid & in_ready, latch in_sig/in_exp, set idx = 3, go to SCAN.
  - SCAN: apply byte idx of the latched sig to the 8-bit encoder slice.
    - Byte nonzero: pos = 8*idx + (highest set bit in that byte); go to CALC.
    - Byte zero and idx = 0: set out_sig = 0, out_exp = 0, out_zero = 1, unf = ovf = 0; go to DONE.
    - Otherwise: idx = idx - 1; stay in SCAN.
  - CALC: one cycle; register results, then go to DONE.
    - pos <= MANT_POS: d = MANT_POS - pos; out_sig = sig << d. If in_exp < d, then out_exp = 0 and out_unf = 1; else out_exp = in_exp - d.
    - pos > MANT_POS: d = pos - MANT_POS; out_sig = sig >> d (logical shift; dropped bits discarded, no sticky bit). If in_exp + d > 2^EXP_W - 1, then out_exp = all-ones and out_ovf = 1; else out_exp = in_exp + d.
    - Compute with EXP_W+1 bits internally.
  - DONE: out_valid = 1; outputs held stable. On out_ready, go to IDLE, deassert out_valid, clear flags. out_sig/out_exp are don't-care after the handshake.
- Latency, counted in edges from the accept edge to the first edge where out_valid = 1:
  - Leading one in byte b: (3 - b) + 3. Byte 3 → 3, byte 0 → 6.
  - Zero operand: 5.
- Throughput: one operation in flight. in_ready = 0 from the accept edge until the DONE handshake completes. A result accepted in DONE allows a new accept no earlier than the next cycle; there is no same-cycle turnaround.
- out_ready held low in DONE: outputs stay stable indefinitely.
- in_valid while busy: ignored; the source must hold its data.
- Inputs are sampled only at the accept edge. Changes to in_sig/in_exp after acceptance have no effect.

Test Plan:
- Reset then idle: out_valid = 0, in_ready = 1, busy = 0. Assert rst mid-SCAN → next cycle in_ready = 1, out_valid = 0, and no result ever appears.
- in_sig = 0x007C9C00, in_exp = 0x87 → out_sig = 0x00F93800, out_exp = 0x86, flags 0, out_valid 4 cycles after accept. Then in_sig = 0x0006E800, in_exp = 0x8A → out_sig = 0x00DD0000, out_exp = 0x85.
- in_sig = 0x01000000, in_exp = 0x7E → out_sig = 0x00800000, out_exp = 0x7F, latency 3. in_sig = 0x80000000, in_exp = 0xFA → out_sig = 0x00800000, out_exp = 0xFF, out_ovf = 1.
- in_sig = 0x00000001, in_exp = 0x10 → out_sig = 0x00800000, out_exp = 0x00, out_unf = 1, latency 6.
- in_sig = 0, in_exp = 0x55 → out_zero = 1, out_sig = 0, out_exp = 0, latency 5.
- Hold out_ready = 0 for 10 cycles in DONE → outputs stable, in_ready = 0, in_valid pulses ignored. Raise out_ready → IDLE next cycle, and the next operand is accepted correctly.
